// File: rtl/drum_mult_pipe.sv
// drum_mult_pipe: pipelined DRUM approximate/exact unsigned multiplier with valid/ready backpressure
module drum_mult_pipe #(
  parameter int N  = 16,
  parameter int K  = 7,
  parameter int TW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            in_exact,
  input  logic [TW-1:0]   in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_r,
  output logic [TW-1:0]   out_tag
);
  localparam int LW = $clog2(N);
  localparam int SW = $clog2(2*N);
  // Shift = leading-one index minus (K-1), or 0 when the operand fits in K-1 bits.
  function automatic logic [LW-1:0] lsh(input logic [N-1:0] x);
    lsh = '0;
    for (int i = K-1; i < N; i++)
      if (x[i]) lsh = LW'(i-K+1);
  endfunction
  function automatic logic [N-1:0] mant(input logic [N-1:0] x, input logic [LW-1:0] s);
    logic [N-1:0] w;
    w = x >> s;
    mant = {{(N-K){1'b0}}, w[K-1:1], w[0] | (|x[N-1:K-1])};
  endfunction
  logic [LW-1:0]  w_sa, w_sb;
  logic           w_ld1, w_ld2, w_ld3;
  logic           r1_v, r2_v, r3_v;
  logic [N-1:0]   r1_a, r1_b;
  logic [SW-1:0]  r1_s, r2_s;
  logic [2*N-1:0] r2_p, r3_r;
  logic [TW-1:0]  r1_t, r2_t, r3_t;
  always_comb begin
    w_sa  = lsh(in_a);
    w_sb  = lsh(in_b);
    w_ld3 = !r3_v || out_ready;
    w_ld2 = !r2_v || w_ld3;
    w_ld1 = !r1_v || w_ld2;
  end
  assign in_ready  = !rst && w_ld1;
  assign out_valid = r3_v;
  assign out_r     = r3_r;
  assign out_tag   = r3_t;
  // Exact mode reuses the S2 multiplier with raw operands and a zero shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v <= 1'b0;
      r1_a <= '0;
      r1_b <= '0;
      r1_s <= '0;
      r1_t <= '0;
      r2_v <= 1'b0;
      r2_p <= '0;
      r2_s <= '0;
      r2_t <= '0;
      r3_v <= 1'b0;
      r3_r <= '0;
      r3_t <= '0;
    end else begin
      if (w_ld1) begin
        r1_v <= in_valid;
        r1_a <= in_exact ? in_a : mant(in_a, w_sa);
        r1_b <= in_exact ? in_b : mant(in_b, w_sb);
        r1_s <= in_exact ? '0 : SW'(w_sa) + SW'(w_sb);
        r1_t <= in_tag;
      end
      if (w_ld2) begin
        r2_v <= r1_v;
        r2_p <= (2*N)'(r1_a) * (2*N)'(r1_b);
        r2_s <= r1_s;
        r2_t <= r1_t;
      end
      if (w_ld3) begin
        r3_v <= r2_v;
        r3_r <= r2_p << r2_s;
        r3_t <= r2_t;
      end
    end
  end
endmodule

// File: tb/tb_drum_mult_pipe.sv
// tb_drum_mult_pipe: directed and random scoreboard bench for drum_mult_pipe
module tb_drum_mult_pipe;
  localparam int N = 16, K = 7, TW = 4;
  logic clk = 0, rst = 1, in_valid = 0, in_exact = 0, out_ready = 1;
  logic [N-1:0] in_a = 0, in_b = 0;
  logic [TW-1:0] in_tag = 0;
  logic in_ready, out_valid;
  logic [2*N-1:0] out_r;
  logic [TW-1:0] out_tag;
  int checks = 0, errors = 0;
  typedef struct { logic [TW-1:0] t; logic [2*N-1:0] r; } item_t;
  item_t q[$];
  logic [2*N-1:0] hr;
  logic [TW-1:0] ht;
  logic hv = 0;
  drum_mult_pipe #(.N(N), .K(K), .TW(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_exact(in_exact), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic e);
    logic [2*N-1:0] m[2];
    int s[2];
    logic [N-1:0] x;
    int k;
    if (e) return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    for (int j = 0; j < 2; j++) begin
      x = j ? b : a;
      k = 0;
      for (int i = 0; i < N; i++) if (x[i]) k = i;
      if (k >= K-1) begin
        m[j] = 1;
        for (int i = 1; i < K-1; i++) m[j][i] = x[k-K+1+i];
        m[j][K-1] = 1'b1;
        s[j] = k-K+1;
      end else begin
        m[j] = {{N{1'b0}}, x};
        s[j] = 0;
      end
    end
    return (m[0] * m[1]) << (s[0] + s[1]);
  endfunction
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      q.delete();
      hv <= 1'b0;
    end else begin
      if (hv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_r", out_r, hr);
        chk("hold_tag", out_tag, ht);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", out_valid, 0);
        else begin
          it = q.pop_front();
          chk("sb_tag", out_tag, it.t);
          chk("sb_r", out_r, it.r);
        end
      end
      hv <= out_valid && !out_ready;
      hr <= out_r;
      ht <= out_tag;
      if (in_valid && in_ready) q.push_back('{in_tag, model(in_a, in_b, in_exact)});
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drain;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 30 && (q.size() > 0 || out_valid); i++) step;
    chk("drain_empty", q.size(), 0);
  endtask
  task automatic send_one(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic e, input logic [2*N-1:0] exp);
    in_valid = 1; in_a = a; in_b = b; in_exact = e; in_tag = 4'h5; out_ready = 1;
    step;
    in_valid = 0;
    step;
    step;
    chk({name, "_early"}, 0, 0);
    step;
  endtask
  task automatic single(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic e, input logic [2*N-1:0] exp);
    in_valid = 1; in_a = a; in_b = b; in_exact = e; in_tag = 4'h5; out_ready = 1;
    #1 chk({name, "_in_ready"}, in_ready, 1);
    step;
    in_valid = 0;
    step;
    chk({name, "_lat_early"}, out_valid, 0);
    step;
    chk({name, "_lat"}, out_valid, 1);
    chk({name, "_r"}, out_r, exp);
    chk({name, "_tag"}, out_tag, 4'h5);
    step;
  endtask
  initial begin
    int n;
    logic acc;
    repeat (3) step;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_tag", out_tag, 0);
    rst = 0;
    #1 chk("post_rst_in_ready", in_ready, 1);
    single("t1_approx", 16'h00FF, 16'h0003, 0, 762);
    single("t1_exact", 16'h00FF, 16'h0003, 1, 765);
    single("t2_approx", 16'hFFFF, 16'hFFFF, 0, 32'hFC040000);
    single("t2_exact", 16'hFFFF, 16'hFFFF, 1, 32'hFFFE0001);
    single("t3_small", 40, 50, 0, 2000);
    single("t3_zero", 0, 16'hFFFF, 0, 0);
    single("t3_zero_exact", 16'hFFFF, 0, 1, 0);
    drain;
    for (int t = 0; t < 11; t++) begin
      in_valid = t < 8; in_a = N'($urandom); in_b = N'($urandom); in_exact = 0; in_tag = TW'(t);
      step;
      if (t >= 2 && t < 10) begin
        chk("t4_b2b_valid", out_valid, 1);
        chk("t4_tag_order", out_tag, TW'(t-2));
      end
    end
    drain;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid = n < 12; in_a = N'($urandom); in_b = N'($urandom); in_exact = c[0]; in_tag = TW'(n);
      #1;
      if (c >= 5 && c < 9) begin
        chk("t5_in_ready_low", in_ready, 0);
        chk("t5_out_valid_held", out_valid, 1);
      end
      acc = in_valid && in_ready;
      step;
      if (acc) n++;
    end
    chk("t5_all_accepted", n, 12);
    drain;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1; in_a = N'($urandom); in_b = N'($urandom); in_exact = 0; in_tag = TW'(t);
      step;
    end
    in_valid = 0;
    rst = 1;
    #1 chk("t6_rst_in_ready", in_ready, 0);
    step;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_r", out_r, 0);
    rst = 0;
    #1 chk("t6_in_ready", in_ready, 1);
    for (int t = 0; t < 4; t++) begin
      step;
      chk("t6_none_emerge", out_valid, 0);
    end
    single("t6_after", 40, 50, 0, 2000);
    for (int c = 0; c < 500; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_a = N'($urandom) >> $urandom_range(0, N-1);
      in_b = N'($urandom) >> $urandom_range(0, N-1);
      in_exact = $urandom % 2;
      in_tag = TW'($urandom);
      step;
    end
    drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
